// File: rtl/fifo_sync.sv
// fifo_sync: single-clock FIFO with standard (registered read) or first-word-fall-through
// output, registered full/empty flags, optional write acknowledge and occupancy count.
module fifo_sync #(
  parameter int FIFO_DEPTH  = 64,
  parameter int BYTE_WIDTH  = 8,
  parameter int COUNT_WIDTH = 8,
  parameter int FWFT        = 0,
  parameter int COUNT_ENA   = 1,
  parameter int DATA_ZERO   = 0,
  parameter int ACK_ENA     = 0,
  parameter     RAM_TYPE    = "block"
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic                    wr_en,
  input  logic [BYTE_WIDTH*8-1:0] wr_data,
  output logic                    wr_ack,
  output logic                    wr_full,
  input  logic                    rd_en,
  output logic [BYTE_WIDTH*8-1:0] rd_data,
  output logic                    rd_valid,
  output logic                    rd_empty,
  output logic [COUNT_WIDTH-1:0]  data_count
);

  localparam int DW = BYTE_WIDTH * 8;
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(FIFO_DEPTH);

  if ((FIFO_DEPTH < 4) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
    $error("fifo_sync: FIFO_DEPTH must be a power of two and at least 4");
  end
  if (COUNT_WIDTH < CW) begin : g_bad_count
    $error("fifo_sync: COUNT_WIDTH too narrow for FIFO_DEPTH");
  end
  if (RAM_TYPE == "") begin : g_bad_ram
    $error("fifo_sync: RAM_TYPE must not be empty");
  end

  (* ram_style = RAM_TYPE *) logic [DW-1:0] mem [FIFO_DEPTH];

  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] mem_count;
  logic [CW-1:0] mem_count_nxt;
  logic [CW-1:0] occ;
  logic [CW-1:0] occ_nxt;
  logic          mem_empty;
  logic          mem_empty_nxt;
  logic          wr_acc;
  logic          fetch;
  logic          pop;
  logic          rd_valid_nxt;
  logic          rd_empty_nxt;

  // fetch moves a word out of the array into rd_data; pop is the consumer-visible read.
  // In FWFT mode the output register acts as an extra stage, so the two differ.
  always_comb begin
    wr_acc = wr_en & ~wr_full;
    if (FWFT != 0) begin
      fetch        = ~mem_empty & (~rd_valid | rd_en);
      pop          = rd_en & rd_valid;
      rd_valid_nxt = fetch | (rd_valid & ~rd_en);
    end else begin
      fetch        = rd_en & ~mem_empty;
      pop          = fetch;
      rd_valid_nxt = fetch;
    end
    mem_count_nxt = mem_count + CW'(wr_acc) - CW'(fetch);
    occ_nxt       = occ + CW'(wr_acc) - CW'(pop);
    // A word written into an empty array becomes readable one cycle later.
    mem_empty_nxt = (mem_count == '0) | (mem_count_nxt == '0);
    rd_empty_nxt  = (FWFT != 0) ? ~rd_valid_nxt : mem_empty_nxt;
  end

  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      mem_count  <= '0;
      occ        <= '0;
      mem_empty  <= 1'b1;
      wr_full    <= 1'b0;
      wr_ack     <= 1'b0;
      rd_empty   <= 1'b1;
      rd_valid   <= 1'b0;
      data_count <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (fetch) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      mem_count  <= mem_count_nxt;
      occ        <= occ_nxt;
      mem_empty  <= mem_empty_nxt;
      wr_full    <= (occ_nxt == DEPTH_C);
      wr_ack     <= (ACK_ENA != 0) & wr_acc;
      rd_empty   <= rd_empty_nxt;
      rd_valid   <= rd_valid_nxt;
      data_count <= (COUNT_ENA != 0) ? COUNT_WIDTH'(occ_nxt) : '0;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rd_data <= '0;
    end else if (fetch) begin
      rd_data <= mem[rd_ptr];
    end else if ((DATA_ZERO != 0) && !rd_valid_nxt) begin
      rd_data <= '0;
    end
  end

endmodule

// File: tb/tb_fifo_sync.sv
// Bench for fifo_sync: a standard-mode instance and an FWFT/ack/zeroing instance,
// both checked against queue-based reference models.
module tb_fifo_sync;

  localparam int DEPTH = 64;
  localparam int DW    = 64;

  logic clk = 1'b0;
  logic rstn;

  logic          s_wr_en, s_rd_en;
  logic [DW-1:0] s_wr_data;
  logic          s_wr_ack, s_wr_full, s_rd_valid, s_rd_empty;
  logic [DW-1:0] s_rd_data;
  logic [7:0]    s_data_count;

  logic          f_wr_en, f_rd_en;
  logic [DW-1:0] f_wr_data;
  logic          f_wr_ack, f_wr_full, f_rd_valid, f_rd_empty;
  logic [DW-1:0] f_rd_data;
  logic [7:0]    f_data_count;

  fifo_sync u_std (
    .clk(clk), .rstn(rstn),
    .wr_en(s_wr_en), .wr_data(s_wr_data), .wr_ack(s_wr_ack), .wr_full(s_wr_full),
    .rd_en(s_rd_en), .rd_data(s_rd_data), .rd_valid(s_rd_valid), .rd_empty(s_rd_empty),
    .data_count(s_data_count)
  );

  fifo_sync #(.FWFT(1), .ACK_ENA(1), .DATA_ZERO(1)) u_fwft (
    .clk(clk), .rstn(rstn),
    .wr_en(f_wr_en), .wr_data(f_wr_data), .wr_ack(f_wr_ack), .wr_full(f_wr_full),
    .rd_en(f_rd_en), .rd_data(f_rd_data), .rd_valid(f_rd_valid), .rd_empty(f_rd_empty),
    .data_count(f_data_count)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Standard-mode reference: queue contents plus expected flag/output values.
  logic [DW-1:0] sm_q[$];
  bit            sm_full = 1'b0;
  bit            sm_empty = 1'b1;
  bit            sm_valid = 1'b0;
  logic [DW-1:0] sm_data = '0;
  int            sm_before;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      sm_q.delete();
      sm_full  = 1'b0;
      sm_empty = 1'b1;
      sm_valid = 1'b0;
      sm_data  = '0;
    end else begin
      sm_before = sm_q.size();
      sm_valid  = s_rd_en && !sm_empty;
      if (sm_valid) sm_data = sm_q.pop_front();
      if (s_wr_en && !sm_full) sm_q.push_back(s_wr_data);
      sm_full  = (sm_q.size() == DEPTH);
      sm_empty = (sm_before == 0) || (sm_q.size() == 0);
    end
  end

  // FWFT reference: ordered scoreboard of stored words tagged with their write edge.
  typedef struct {
    logic [DW-1:0] d;
    int            w;
  } ent_t;
  ent_t fm_q[$];
  bit   fm_full = 1'b0;
  bit   fm_ack = 1'b0;
  int   cyc = 0;
  bit   f_valid_s = 1'b0;

  always @(negedge clk) f_valid_s = f_rd_valid;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fm_q.delete();
      fm_full = 1'b0;
      fm_ack  = 1'b0;
    end else begin
      cyc++;
      if (f_rd_en && f_valid_s && fm_q.size() > 0) void'(fm_q.pop_front());
      fm_ack = f_wr_en && !fm_full;
      if (fm_ack) fm_q.push_back('{f_wr_data, cyc});
      fm_full = (fm_q.size() == DEPTH);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rstn = 1'b0;
    s_wr_en = 0; s_rd_en = 0; s_wr_data = '0;
    f_wr_en = 0; f_rd_en = 0; f_wr_data = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({s_wr_full, s_rd_empty, s_rd_valid, s_wr_ack} !== 4'b0100) begin
      errors++; $display("FAIL reset_std_flags got %b want 0100", {s_wr_full, s_rd_empty, s_rd_valid, s_wr_ack});
    end
    checks++;
    if (s_rd_data !== '0 || s_data_count !== 8'd0) begin
      errors++; $display("FAIL reset_std_data got data=%h count=%0d want 0/0", s_rd_data, s_data_count);
    end
    checks++;
    if ({f_wr_full, f_rd_empty, f_rd_valid, f_wr_ack} !== 4'b0100 || f_data_count !== 8'd0) begin
      errors++; $display("FAIL reset_fwft got flags=%b count=%0d want 0100/0",
                         {f_wr_full, f_rd_empty, f_rd_valid, f_wr_ack}, f_data_count);
    end
    rstn = 1'b1;
    step();
    checks++;
    if (s_rd_empty !== 1'b1 || s_data_count !== 8'd0) begin
      errors++; $display("FAIL reset_release got empty=%b count=%0d want 1/0", s_rd_empty, s_data_count);
    end
  endtask

  task automatic test_fill_drain();
    int pulses = 0;
    for (int i = 0; i < DEPTH; i++) begin
      s_wr_en = 1; s_wr_data = DW'(i);
      step();
      checks++;
      if (s_data_count !== 8'(i + 1) || s_wr_full !== (i == DEPTH - 1)) begin
        errors++; $display("FAIL fill[%0d] got count=%0d full=%b want %0d/%b", i, s_data_count, s_wr_full, i + 1, i == DEPTH - 1);
      end
    end
    s_wr_data = 64'hDEAD;
    step();
    checks++;
    if (s_data_count !== 8'd64 || s_wr_full !== 1'b1) begin
      errors++; $display("FAIL overfill got count=%0d full=%b want 64/1", s_data_count, s_wr_full);
    end
    s_wr_en = 0; s_rd_en = 1;
    for (int k = 0; k < 66; k++) begin
      step();
      if (s_rd_valid === 1'b1) pulses++;
      checks++;
      if (s_rd_valid !== (k < 64)) begin
        errors++; $display("FAIL drain_valid[%0d] got %b want %b", k, s_rd_valid, k < 64);
      end
      if (k < 64) begin
        checks++;
        if (s_rd_data !== DW'(k)) begin
          errors++; $display("FAIL drain_data[%0d] got %h want %h", k, s_rd_data, DW'(k));
        end
      end
      checks++;
      if (s_data_count !== 8'(k < 63 ? 63 - k : 0) || s_rd_empty !== (k >= 63) || s_wr_full !== 1'b0) begin
        errors++; $display("FAIL drain_state[%0d] got count=%0d empty=%b full=%b want %0d/%b/0",
                           k, s_data_count, s_rd_empty, s_wr_full, k < 63 ? 63 - k : 0, k >= 63);
      end
    end
    s_rd_en = 0;
    checks++;
    if (pulses != 64) begin
      errors++; $display("FAIL drain_pulses got %0d want 64", pulses);
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 0; i < 32; i++) begin
      s_wr_en = 1; s_wr_data = DW'(100 + i);
      step();
    end
    s_rd_en = 1;
    for (int i = 0; i < 10; i++) begin
      s_wr_data = DW'(200 + i);
      step();
      checks++;
      if (s_data_count !== 8'd32 || s_rd_valid !== 1'b1 || s_rd_data !== DW'(100 + i)) begin
        errors++; $display("FAIL simul[%0d] got count=%0d valid=%b data=%0d want 32/1/%0d",
                           i, s_data_count, s_rd_valid, s_rd_data, 100 + i);
      end
    end
    s_rd_en = 0;
    for (int i = 0; i < 32; i++) begin
      s_wr_data = DW'(300 + i);
      step();
    end
    checks++;
    if (s_wr_full !== 1'b1 || s_data_count !== 8'd64) begin
      errors++; $display("FAIL simul_fill got full=%b count=%0d want 1/64", s_wr_full, s_data_count);
    end
    s_rd_en = 1; s_wr_data = 64'hBAD;
    step();
    s_wr_en = 0;
    checks++;
    if (s_data_count !== 8'd63 || s_wr_full !== 1'b0 || s_rd_valid !== 1'b1 || s_rd_data !== DW'(110)) begin
      errors++; $display("FAIL simul_full got count=%0d full=%b valid=%b data=%0d want 63/0/1/110",
                         s_data_count, s_wr_full, s_rd_valid, s_rd_data);
    end
    for (int k = 0; k < 66; k++) begin
      step();
      checks++;
      if (s_rd_valid !== sm_valid || s_rd_data !== sm_data || s_data_count !== 8'(sm_q.size())) begin
        errors++; $display("FAIL simul_drain[%0d] got valid=%b data=%0d count=%0d want %b/%0d/%0d",
                           k, s_rd_valid, s_rd_data, s_data_count, sm_valid, sm_data, sm_q.size());
      end
    end
    s_rd_en = 0;
  endtask

  task automatic test_wrap();
    logic [DW-1:0] in_q[$];
    logic [DW-1:0] out_q[$];
    int sent = 0;
    int bad = 0;
    for (int c = 0; c < 3000 && out_q.size() < 200; c++) begin
      s_wr_en = (sent < 200) && (sm_q.size() < 10) && ($urandom_range(0, 3) != 0);
      if (s_wr_en) begin
        s_wr_data = {$urandom, $urandom};
        in_q.push_back(s_wr_data);
        sent++;
      end
      s_rd_en = $urandom_range(0, 1) == 1;
      step();
      if (s_rd_valid === 1'b1) out_q.push_back(s_rd_data);
      checks++;
      if ({s_rd_valid, s_rd_empty, s_wr_full} !== {sm_valid, sm_empty, sm_full} ||
          s_rd_data !== sm_data || s_data_count !== 8'(sm_q.size())) begin
        errors++; $display("FAIL wrap_cycle[%0d] got v/e/f=%b data=%h count=%0d want %b data=%h count=%0d",
                           c, {s_rd_valid, s_rd_empty, s_wr_full}, s_rd_data, s_data_count,
                           {sm_valid, sm_empty, sm_full}, sm_data, sm_q.size());
      end
    end
    s_wr_en = 0; s_rd_en = 0;
    checks++;
    if (out_q.size() != 200 || in_q.size() != 200) begin
      errors++; $display("FAIL wrap_len got out=%0d in=%0d want 200/200", out_q.size(), in_q.size());
    end else begin
      for (int i = 0; i < 200; i++) if (out_q[i] !== in_q[i]) bad++;
      if (bad != 0) begin
        errors++; $display("FAIL wrap_order got %0d mismatched words want 0", bad);
      end
    end
  endtask

  task automatic test_reset_mid();
    int got = 0;
    int bad = 0;
    for (int i = 0; i < 20; i++) begin
      s_wr_en = 1; s_wr_data = DW'(500 + i);
      step();
    end
    s_wr_en = 0;
    checks++;
    if (s_data_count !== 8'd20) begin
      errors++; $display("FAIL pre_reset_count got %0d want 20", s_data_count);
    end
    #2 rstn = 1'b0;
    #1;
    checks++;
    if ({s_wr_full, s_rd_empty, s_rd_valid} !== 3'b010 || s_data_count !== 8'd0 || s_rd_data !== '0) begin
      errors++; $display("FAIL reset_mid got f/e/v=%b count=%0d data=%h want 010/0/0",
                         {s_wr_full, s_rd_empty, s_rd_valid}, s_data_count, s_rd_data);
    end
    @(posedge clk);
    #1 rstn = 1'b1;
    s_wr_en = 1; s_wr_data = 64'h1234;
    step();
    s_wr_en = 0;
    checks++;
    if (s_data_count !== 8'd1) begin
      errors++; $display("FAIL post_reset_write got count=%0d want 1", s_data_count);
    end
    s_rd_en = 1;
    repeat (4) begin
      step();
      if (s_rd_valid === 1'b1) begin
        got++;
        if (s_rd_data !== 64'h1234) bad++;
      end
    end
    s_rd_en = 0;
    checks++;
    if (got != 1 || bad != 0 || s_rd_empty !== 1'b1 || s_data_count !== 8'd0) begin
      errors++; $display("FAIL post_reset_read got reads=%0d wrong=%0d empty=%b count=%0d want 1/0/1/0",
                         got, bad, s_rd_empty, s_data_count);
    end
  endtask

  task automatic test_fwft_directed();
    f_wr_en = 1; f_wr_data = 64'hA5;
    step();
    f_wr_en = 0;
    checks++;
    if (f_wr_ack !== 1'b1 || f_rd_valid !== 1'b0 || f_data_count !== 8'd1) begin
      errors++; $display("FAIL fwft_w1 got ack=%b valid=%b count=%0d want 1/0/1", f_wr_ack, f_rd_valid, f_data_count);
    end
    step();
    checks++;
    if (f_wr_ack !== 1'b0 || f_rd_valid !== 1'b0 || f_rd_data !== '0) begin
      errors++; $display("FAIL fwft_w2 got ack=%b valid=%b data=%h want 0/0/0", f_wr_ack, f_rd_valid, f_rd_data);
    end
    step();
    checks++;
    if (f_rd_valid !== 1'b1 || f_rd_data !== 64'hA5 || f_rd_empty !== 1'b0) begin
      errors++; $display("FAIL fwft_show got valid=%b data=%h empty=%b want 1/a5/0", f_rd_valid, f_rd_data, f_rd_empty);
    end
    f_rd_en = 1;
    step();
    f_rd_en = 0;
    checks++;
    if (f_rd_valid !== 1'b0 || f_rd_data !== '0 || f_rd_empty !== 1'b1 || f_data_count !== 8'd0) begin
      errors++; $display("FAIL fwft_pop got valid=%b data=%h empty=%b count=%0d want 0/0/1/0",
                         f_rd_valid, f_rd_data, f_rd_empty, f_data_count);
    end
    for (int i = 0; i < 5; i++) begin
      f_wr_en = 1; f_wr_data = DW'(64'hB0 + i);
      step();
    end
    f_wr_en = 0; f_rd_en = 1;
    for (int k = 0; k < 5; k++) begin
      checks++;
      if (f_rd_valid !== 1'b1 || f_rd_data !== DW'(64'hB0 + k)) begin
        errors++; $display("FAIL fwft_b2b[%0d] got valid=%b data=%h want 1/%h", k, f_rd_valid, f_rd_data, 64'hB0 + k);
      end
      step();
    end
    f_rd_en = 0;
    checks++;
    if (f_rd_valid !== 1'b0 || f_rd_empty !== 1'b1) begin
      errors++; $display("FAIL fwft_b2b_end got valid=%b empty=%b want 0/1", f_rd_valid, f_rd_empty);
    end
  endtask

  task automatic test_fwft_random();
    for (int c = 0; c < 450; c++) begin
      if (c < 150) begin
        f_wr_en = $urandom_range(0, 9) != 0;
        f_rd_en = $urandom_range(0, 4) == 0;
      end else if (c < 300) begin
        f_wr_en = $urandom_range(0, 1) == 1;
        f_rd_en = $urandom_range(0, 1) == 1;
      end else begin
        f_wr_en = $urandom_range(0, 4) == 0;
        f_rd_en = $urandom_range(0, 9) != 0;
      end
      f_wr_data = {$urandom, $urandom};
      step();
      checks++;
      if (f_wr_ack !== fm_ack || f_wr_full !== fm_full || f_data_count !== 8'(fm_q.size()) ||
          f_rd_empty !== ~f_rd_valid) begin
        errors++; $display("FAIL fwft_state[%0d] got ack=%b full=%b count=%0d empty=%b want %b/%b/%0d/%b",
                           c, f_wr_ack, f_wr_full, f_data_count, f_rd_empty, fm_ack, fm_full, fm_q.size(), ~f_rd_valid);
      end
      checks++;
      if (f_rd_valid === 1'b1) begin
        if (fm_q.size() == 0 || f_rd_data !== fm_q[0].d) begin
          errors++; $display("FAIL fwft_head[%0d] got %h want %h", c, f_rd_data, fm_q.size() > 0 ? fm_q[0].d : '0);
        end
      end else if (f_rd_data !== '0 || (fm_q.size() > 0 && fm_q[0].w + 2 <= cyc)) begin
        errors++; $display("FAIL fwft_idle[%0d] got valid=%b data=%h want valid=%b data=0",
                           c, f_rd_valid, f_rd_data, fm_q.size() > 0 && fm_q[0].w + 2 <= cyc);
      end
    end
    f_wr_en = 0; f_rd_en = 0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got timeout want completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_fill_drain();
    test_simultaneous();
    test_wrap();
    test_reset_mid();
    test_fwft_directed();
    test_fwft_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
